// File: rtl/pipo_bank_arbiter_pkg.sv
// Shared types and defaults for the register-bank write arbiter.
// FSM encoding and parameter defaults live here.
package pipo_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREG  = 4;
  localparam int DEF_AW    = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipo_bank_arbiter_rr_arbiter_core.sv
// Combinational round-robin pick: first request at or above ptr,
// wrapping modulo NREQ.
module rr_arbiter_core
  import pipo_bank_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = idx_w(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   gnt,
  output logic            valid
);

  int best;

  // Smallest circular distance from ptr wins.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    best  = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      int d;
      d = (j - int'(ptr) + NREQ) % NREQ;
      if (req[j] && d < best) begin
        best  = d;
        gnt   = PW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipo_bank_arbiter.sv
// Round-robin shared PIPO register bank with REQ/ACK write handshake.
// Three-cycle write transaction: IDLE grant, LOAD write, DONE ack.
module pipo_bank_arbiter
  import pipo_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*AW-1:0]    WADDR,
  input  logic [NREQ*WIDTH-1:0] WDATA,
  output logic [NREQ-1:0]       ACK,
  output logic                  BUSY,
  input  logic [AW-1:0]         RADDR,
  output logic [WIDTH-1:0]      RDATA,
  output logic [NREG*WIDTH-1:0] OUT
);

  localparam int PW = idx_w(NREQ);

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gidx;
  logic [AW-1:0]     laddr;
  logic [WIDTH-1:0]  ldata;
  logic [NREQ-1:0]   ack_q;
  logic [WIDTH-1:0]  regs [NREG];

  logic [AW-1:0]     wa [NREQ];
  logic [WIDTH-1:0]  wd [NREQ];
  logic [PW-1:0]     gnt;
  logic              gvalid;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign wa[i] = WADDR[i*AW +: AW];
    assign wd[i] = WDATA[i*WIDTH +: WIDTH];
  end

  for (genvar j = 0; j < NREG; j++) begin : g_out
    assign OUT[j*WIDTH +: WIDTH] = regs[j];
  end

  rr_arbiter_core #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req   (REQ),
    .ptr   (ptr),
    .gnt   (gnt),
    .valid (gvalid)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      laddr <= '0;
      ldata <= '0;
      ack_q <= '0;
      for (int j = 0; j < NREG; j++)
        regs[j] <= '0;
    end else begin
      ack_q <= '0;
      unique case (state)
        IDLE: begin
          if (gvalid) begin
            gidx  <= gnt;
            laddr <= wa[gnt];
            ldata <= wd[gnt];
            state <= LOAD;
          end
        end
        LOAD: begin
          // Addresses past the bank match no register and drop.
          for (int j = 0; j < NREG; j++)
            if (laddr == AW'(j))
              regs[j] <= ldata;
          ack_q <= NREQ'(1) << gidx;
          state <= DONE;
        end
        DONE: begin
          if (gidx == PW'(NREQ - 1))
            ptr <= '0;
          else
            ptr <= gidx + PW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ACK  = ack_q;
  assign BUSY = (state != IDLE);

  always_comb begin
    RDATA = '0;
    for (int j = 0; j < NREG; j++)
      if (RADDR == AW'(j))
        RDATA = regs[j];
  end

endmodule

// File: tb/tb_pipo_bank_arbiter.sv
// Self-checking bench for pipo_bank_arbiter with a transaction-level
// reference model of the bank and the round-robin pointer.
module tb_pipo_bank_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  REQ = '0;
  logic [7:0]  WADDR;
  logic [15:0] WDATA;
  logic [3:0]  ACK;
  logic        BUSY;
  logic [1:0]  RADDR = '0;
  logic [3:0]  RDATA;
  logic [15:0] OUT;

  logic [1:0] la [4];
  logic [3:0] ld [4];

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] mem [4];
  int         mptr;

  always #5 CLK = ~CLK;

  always_comb begin
    WADDR = {la[3], la[2], la[1], la[0]};
    WDATA = {ld[3], ld[2], ld[1], ld[0]};
  end

  pipo_bank_arbiter dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .WADDR (WADDR),
    .WDATA (WDATA),
    .ACK   (ACK),
    .BUSY  (BUSY),
    .RADDR (RADDR),
    .RDATA (RDATA),
    .OUT   (OUT)
  );

  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (mptr + i) % 4;
      if (r[k[1:0]]) return k;
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_out();
    return {mem[3], mem[2], mem[1], mem[0]};
  endfunction

  // Advance the model by one granted transaction; returns expected ACK.
  task automatic model_txn(input logic [3:0] r,
                           output logic [3:0] exp_ack);
    int g;
    g = pick(r);
    exp_ack = '0;
    if (g >= 0) begin
      mem[la[g[1:0]]] = ld[g[1:0]];
      mptr = (g + 1) % 4;
      exp_ack = 4'(1) << g;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem[i] = '0;
    mptr = 0;
  endtask

  task automatic wait_ack(output logic [3:0] a);
    a = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      if (ACK != 0) begin
        a = ACK;
        break;
      end
    end
  endtask

  task automatic go_idle();
    REQ = '0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    vectors++;
    if (OUT !== 16'h0 || ACK !== 4'h0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_init: OUT=%h ACK=%b BUSY=%b want 0",
               OUT, ACK, BUSY);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    la[1] = 2'd2; ld[1] = 4'b1010;
    REQ = 4'b0010;
    @(posedge CLK); #1;
    vectors++;
    if (BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_grant_busy: BUSY=%b want 1", BUSY);
    end
    #2 RST = 1'b0;
    #1;
    vectors++;
    if (OUT !== 16'h0 || ACK !== 4'h0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midload: OUT=%h ACK=%b BUSY=%b want 0",
               OUT, ACK, BUSY);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      vectors++;
      if (OUT !== 16'h0 || ACK !== 4'h0 || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_held: OUT=%h ACK=%b BUSY=%b want 0",
                 OUT, ACK, BUSY);
      end
    end
    REQ = '0;
    @(posedge CLK); #1;
    RST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      vectors++;
      if (ACK !== 4'h0 || OUT !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_no_ack: ACK=%b OUT=%h want 0", ACK, OUT);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] a, e;
    for (int i = 0; i < 4; i++) begin
      la[i] = 2'(i);
      ld[i] = 4'(i);
    end
    REQ = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      model_txn(REQ, e);
      wait_ack(a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL fair_ack[%0d]: got %b want %b", t, a, e);
      end
      if (t == 3) begin
        vectors++;
        if (OUT !== 16'h3210) begin
          miscompares++;
          $display("FAIL fair_out: got %h want 3210", OUT);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_single_write();
    logic [3:0] e;
    la[0] = 2'd1; ld[0] = 4'b1010;
    RADDR = 2'd1;
    REQ = 4'b0001;
    model_txn(REQ, e);
    @(posedge CLK); #1;
    vectors++;
    if (ACK !== 4'h0 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL single_load: ACK=%b BUSY=%b want 0000/1",
               ACK, BUSY);
    end
    @(posedge CLK); #1;
    vectors++;
    if (ACK !== e) begin
      miscompares++;
      $display("FAIL single_ack: got %b want %b", ACK, e);
    end
    vectors++;
    if (OUT[7:4] !== 4'b1010 || RDATA !== 4'b1010) begin
      miscompares++;
      $display("FAIL single_data: OUT[7:4]=%b RDATA=%b want 1010",
               OUT[7:4], RDATA);
    end
    REQ = '0;
    @(posedge CLK); #1;
    vectors++;
    if (ACK !== 4'h0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: ACK=%b BUSY=%b want 0", ACK, BUSY);
    end
  endtask

  task automatic test_withdraw();
    logic [3:0] a, e;
    la[2] = 2'd3; ld[2] = 4'b0110;
    REQ = 4'b0100;
    model_txn(REQ, e);
    @(posedge CLK); #1;
    REQ = '0;
    la[2] = 2'd0; ld[2] = 4'b1111;
    wait_ack(a);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL withdraw_ack: got %b want %b", a, e);
    end
    vectors++;
    if (OUT !== model_out()) begin
      miscompares++;
      $display("FAIL withdraw_out: got %h want %h", OUT, model_out());
    end
    go_idle();
  endtask

  task automatic test_wrap();
    logic [3:0] a, e;
    logic [3:0] seq [3];
    seq[0] = 4'b1000;
    seq[1] = 4'b1001;
    seq[2] = 4'b1000;
    la[0] = 2'd2; ld[0] = 4'b0101;
    la[3] = 2'd1; ld[3] = 4'b1110;
    for (int t = 0; t < 3; t++) begin
      REQ = seq[t];
      model_txn(REQ, e);
      wait_ack(a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL wrap_ack[%0d]: got %b want %b", t, a, e);
      end
    end
    vectors++;
    if (OUT !== model_out()) begin
      miscompares++;
      $display("FAIL wrap_out: got %h want %h", OUT, model_out());
    end
    go_idle();
  endtask

  task automatic test_read_during_write();
    logic [3:0] a, e;
    la[1] = 2'd0; ld[1] = 4'b0011;
    REQ = 4'b0010;
    model_txn(REQ, e);
    wait_ack(a);
    go_idle();
    RADDR = 2'd0;
    la[2] = 2'd0; ld[2] = 4'b1100;
    REQ = 4'b0100;
    model_txn(REQ, e);
    @(posedge CLK); #1;
    vectors++;
    if (RDATA !== 4'b0011 || OUT[3:0] !== 4'b0011) begin
      miscompares++;
      $display("FAIL rdw_load: RDATA=%b OUT[3:0]=%b want 0011",
               RDATA, OUT[3:0]);
    end
    @(posedge CLK); #1;
    vectors++;
    if (RDATA !== 4'b1100 || ACK !== e) begin
      miscompares++;
      $display("FAIL rdw_done: RDATA=%b ACK=%b want 1100/%b",
               RDATA, ACK, e);
    end
    go_idle();
  endtask

  task automatic test_random();
    logic [3:0] a, e;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        la[i] = 2'($urandom_range(0, 3));
        ld[i] = 4'($urandom);
      end
      RADDR = 2'($urandom_range(0, 3));
      REQ = 4'($urandom_range(1, 15));
      model_txn(REQ, e);
      wait_ack(a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL rand_ack[%0d]: got %b want %b", t, a, e);
      end
      vectors++;
      if (OUT !== model_out() || RDATA !== mem[RADDR]) begin
        miscompares++;
        $display("FAIL rand_data[%0d]: OUT=%h RDATA=%h want %h/%h",
                 t, OUT, RDATA, model_out(), mem[RADDR]);
      end
    end
    go_idle();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      la[i] = '0;
      ld[i] = '0;
    end
    test_reset();
    test_fairness();
    test_single_write();
    test_withdraw();
    test_wrap();
    test_read_during_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
